// File: rtl/clarke_pipe.sv
// Three-stage Clarke transform (abc -> alpha/beta) with valid/ready flow control,
// per-sample two/three-phase mode, channel tag pass-through and saturating outputs.
module clarke_pipe #(
  parameter int unsigned D_WIDTH = 18,
  parameter int unsigned Q_BITS  = 15,
  parameter int unsigned N_CH    = 4,
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mode,
  input  logic [CH_W-1:0]           ch_in,
  input  logic signed [D_WIDTH-1:0] a,
  input  logic signed [D_WIDTH-1:0] b,
  input  logic signed [D_WIDTH-1:0] c,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH_W-1:0]           ch_out,
  output logic signed [D_WIDTH-1:0] alpha,
  output logic signed [D_WIDTH-1:0] beta,
  output logic                      sat,
  output logic                      sat_seen,
  input  logic                      sat_clr
);

  localparam int unsigned SW = D_WIDTH + 2;
  localparam int unsigned KW = Q_BITS + 1;
  localparam int unsigned PW = SW + KW;
  localparam int unsigned RW = PW - Q_BITS;

  localparam real K1_REAL = (2.0 ** Q_BITS) / $sqrt(3.0);
  localparam logic signed [KW-1:0] K1 = KW'($rtoi(K1_REAL + 0.5));
  localparam logic signed [KW-1:0] K3 = KW'(((2 ** Q_BITS) + 1) / 3);
  localparam logic signed [PW-1:0] RND = PW'(1) << (Q_BITS - 1);
  localparam logic signed [RW-1:0] R_MAX = RW'((2 ** (D_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] R_MIN = ~R_MAX;

  logic adv;

  // Stage 1 registers
  logic                 s1_valid;
  logic                 s1_mode;
  logic [CH_W-1:0]      s1_ch;
  logic signed [SW-1:0] s1_sa;
  logic signed [SW-1:0] s1_sb;

  // Stage 2 registers
  logic                 s2_valid;
  logic [CH_W-1:0]      s2_ch;
  logic signed [PW-1:0] s2_pa;
  logic signed [PW-1:0] s2_pb;

  // Next-state combinational values
  logic signed [SW-1:0] a_ext, b_ext, c_ext;
  logic signed [SW-1:0] sa_d, sb_d;
  logic signed [PW-1:0] sa_w, sb_w;
  logic signed [PW-1:0] pa_d, pb_d;
  logic signed [PW-1:0] pa_rnd, pb_rnd;
  logic [D_WIDTH:0]     clip_a, clip_b;

  // Returns {clipped, value}.
  function automatic logic [D_WIDTH:0] clip(input logic signed [RW-1:0] r);
    if (r > R_MAX) begin
      return {1'b1, R_MAX[D_WIDTH-1:0]};
    end else if (r < R_MIN) begin
      return {1'b1, R_MIN[D_WIDTH-1:0]};
    end else begin
      return {1'b0, r[D_WIDTH-1:0]};
    end
  endfunction

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    a_ext = SW'(a);
    b_ext = SW'(b);
    c_ext = SW'(c);
    if (mode) begin
      sa_d = (a_ext <<< 1) - b_ext - c_ext;
      sb_d = b_ext - c_ext;
    end else begin
      sa_d = a_ext;
      sb_d = a_ext + (b_ext <<< 1);
    end
  end

  always_comb begin
    sa_w = PW'(s1_sa);
    sb_w = PW'(s1_sb);
    pb_d = sb_w * PW'(K1);
    if (s1_mode) begin
      pa_d = sa_w * PW'(K3);
    end else begin
      pa_d = sa_w <<< Q_BITS;
    end
  end

  // Round half up, then keep the integer part before clipping.
  always_comb begin
    pa_rnd = s2_pa + RND;
    pb_rnd = s2_pb + RND;
    clip_a = clip(pa_rnd[PW-1:Q_BITS]);
    clip_b = clip(pb_rnd[PW-1:Q_BITS]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      ch_out    <= '0;
      alpha     <= '0;
      beta      <= '0;
      sat       <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_mode   <= mode;
      s1_ch     <= ch_in;
      s1_sa     <= sa_d;
      s1_sb     <= sb_d;
      s2_valid  <= s1_valid;
      s2_ch     <= s1_ch;
      s2_pa     <= pa_d;
      s2_pb     <= pb_d;
      out_valid <= s2_valid;
      ch_out    <= s2_ch;
      alpha     <= clip_a[D_WIDTH-1:0];
      beta      <= clip_b[D_WIDTH-1:0];
      sat       <= clip_a[D_WIDTH] | clip_b[D_WIDTH];
    end
  end

  // A clip leaving the block in the same cycle as sat_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_seen <= 1'b0;
    end else begin
      sat_seen <= (sat_seen && !sat_clr) || (out_valid && out_ready && sat);
    end
  end

endmodule

// File: tb/tb_clarke_pipe.sv
// Directed bench for clarke_pipe: latency, both modes, saturation flags,
// backpressure, randomly throttled streaming of a hand-computed vector table, reset flush.
module tb_clarke_pipe;

  localparam int DW = 18;
  localparam int CW = 2;
  localparam int NV = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 mode = 1'b0;
  logic [CW-1:0]        ch_in = '0;
  logic signed [DW-1:0] a = '0;
  logic signed [DW-1:0] b = '0;
  logic signed [DW-1:0] c = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [CW-1:0]        ch_out;
  logic signed [DW-1:0] alpha;
  logic signed [DW-1:0] beta;
  logic                 sat;
  logic                 sat_seen;
  logic                 sat_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // mode, a, b, c -> expected alpha, beta, sat (hand-computed, Q15 constants 18919 / 10923)
  int vm [NV] = '{0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0};
  int va [NV] = '{16384, 16384, 131071, -131072, 0, 1000, 16384, -100, 131071, -1, 1, 100};
  int vb [NV] = '{0, -8192, 131071, -131072, 1000, 2000, 0, 50, -131072, 0, 0, -50};
  int vc [NV] = '{0, -8192, 0, 0, 0, 3000, 12345, 50, -131072, 0, -5, 0};
  int ea [NV] = '{16384, 16385, 131071, -131072, 0, -1000, 16384, -100, 131071, -1, 1, 100};
  int eb [NV] = '{9460, 0, 131071, -131072, 1155, -577, 9460, 0, 0, -1, 1, 0};
  int es [NV] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0};

  int bp_idx [6] = '{4, 5, 7, 9, 10, 11};
  int q_idx [$];
  int q_tag [$];
  int acc, sent, got, cyc, i0, t0;

  clarke_pipe #(
    .D_WIDTH(DW),
    .Q_BITS (15),
    .N_CH   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .ch_in    (ch_in),
    .a        (a),
    .b        (b),
    .c        (c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ch_out   (ch_out),
    .alpha    (alpha),
    .beta     (beta),
    .sat      (sat),
    .sat_seen (sat_seen),
    .sat_clr  (sat_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input int tag);
    mode  = (vm[idx] != 0);
    a     = DW'(va[idx]);
    b     = DW'(vb[idx]);
    c     = DW'(vc[idx]);
    ch_in = CW'(tag);
  endtask

  task automatic chk_vec(input string tag, input int idx, input int ch);
    chk({tag, ".alpha"}, alpha, ea[idx]);
    chk({tag, ".beta"}, beta, eb[idx]);
    chk({tag, ".sat"}, sat, es[idx]);
    chk({tag, ".ch"}, ch_out, ch);
  endtask

  // Single sample through an idle pipe with out_ready held high.
  task automatic run_vec(input int idx, input int tag, input bit clr);
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    load(idx, tag);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, ".lat2"}, out_valid, 0);
    @(posedge clk); #1;
    chk({nm, ".lat3"}, out_valid, 1);
    chk_vec(nm, idx, tag);
    sat_clr = clr;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk({nm, ".drain"}, out_valid, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.alpha", alpha, 0);
    chk("rst.beta", beta, 0);
    chk("rst.ch", ch_out, 0);
    chk("rst.sat", sat, 0);
    chk("rst.sat_seen", sat_seen, 0);
    chk("rst.in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0, mode 1, c ignored in mode 0
    run_vec(0, 0, 1'b0);
    run_vec(1, 1, 1'b0);
    run_vec(6, 2, 1'b0);
    chk("nosat.sat_seen", sat_seen, 0);

    // Saturation and the sticky flag
    run_vec(2, 3, 1'b0);
    chk("sat_hi.sat_seen", sat_seen, 1);
    run_vec(3, 0, 1'b0);
    @(negedge clk);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr.sat_seen", sat_seen, 0);
    run_vec(8, 1, 1'b1);
    chk("clr_vs_clip.sat_seen", sat_seen, 1);
    @(negedge clk);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr2.sat_seen", sat_seen, 0);
    run_vec(9, 2, 1'b0);
    run_vec(10, 3, 1'b0);

    // Backpressure: six offered, three accepted
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      load(bp_idx[i], i % 4);
      in_valid = 1'b1;
      #1;
      if (in_ready) acc++;
      if (i >= 4) chk($sformatf("bp.hold%0d", i), alpha, ea[bp_idx[0]]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp.accepted", acc, 3);
    chk("bp.in_ready", in_ready, 0);
    chk("bp.out_valid", out_valid, 1);
    chk_vec("bp0", bp_idx[0], 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp1.valid", out_valid, 1);
    chk_vec("bp1", bp_idx[1], 1);
    @(posedge clk); #1;
    chk("bp2.valid", out_valid, 1);
    chk_vec("bp2", bp_idx[2], 2);
    @(posedge clk); #1;
    chk("bp.empty", out_valid, 0);

    // Mixed-mode stream with random in_valid/out_ready
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 200 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 200 && $urandom_range(0, 3) != 0) begin
        load(sent % NV, sent % 4);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (q_idx.size() == 0) begin
          chk("stream.spurious", out_valid, 0);
        end else begin
          i0 = q_idx.pop_front();
          t0 = q_tag.pop_front();
          chk_vec($sformatf("s%0d", got), i0, t0);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q_idx.push_back(sent % NV);
        q_tag.push_back(sent % 4);
        sent++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream.count", got, 200);
    chk("stream.left", q_idx.size(), 0);

    // Reset with two samples in flight
    @(negedge clk);
    load(0, 1);
    in_valid = 1'b1;
    @(negedge clk);
    load(5, 2);
    @(negedge clk);
    in_valid = 1'b0;
    chk("flush.pre_sat_seen", sat_seen, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("flush.out_valid", out_valid, 0);
    chk("flush.alpha", alpha, 0);
    chk("flush.beta", beta, 0);
    chk("flush.ch", ch_out, 0);
    chk("flush.sat", sat, 0);
    chk("flush.sat_seen", sat_seen, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("flush.gone%0d", i), out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
